ddr_line_buffer: RTL and testbench

- Single-line write-back buffer between the CPU word port (32-bit, byte enables) and the DDR line port (256-bit line).
- Hits are served from a local 256-bit line register.
- A miss triggers an optional dirty write-back, then a line refill over the DDR line handshake, with the CPU stalled throughout.
- Sits directly upstream of the DDR control block; drives its ram_en/ram_write/ram_addr/data_to_ram and consumes ram_rdy/data_to_cpu.

---
 rtl/ddr_line_pkg.sv | 17 +
 rtl/ddr_line_merge.sv | 24 ++
 rtl/ddr_line_buffer.sv | 171 +++++++++++++++++
 tb/tb_ddr_line_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_line_pkg.sv
// rtl/ddr_line_pkg.sv - shared constants and FSM state type for the DDR line buffer
package ddr_line_pkg;

  localparam int LINE_W         = 256;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFF_W          = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_WB_GAP,
    ST_RF,
    ST_RF_GAP
  } state_t;

endpackage

// File: rtl/ddr_line_merge.sv
// rtl/ddr_line_merge.sv - word select and byte-enable merge into a 256-bit line
module ddr_line_merge
  import ddr_line_pkg::*;
(
  input  logic [LINE_W-1:0] i_line,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [3:0]        i_be,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_word,
  output logic [LINE_W-1:0] o_line
);

  // Select the addressed word and build the line with enabled bytes replaced
  always_comb begin
    o_word = i_line[32'(i_off)*WORD_W +: WORD_W];
    o_line = i_line;
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        o_line[32'(i_off)*WORD_W + b*8 +: 8] = i_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/ddr_line_buffer.sv
// rtl/ddr_line_buffer.sv - single-line write-back buffer, CPU word port to DDR line port (optional DDR_LINE_STATS_EN counters)
module ddr_line_buffer
  import ddr_line_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ddr_calib,
  output logic              ddr_en,
  output logic              ddr_write,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [255:0]      ddr_wdata,
  input  logic [255:0]      ddr_rdata,
  input  logic              ddr_rdy
`ifdef DDR_LINE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbs
`endif
);

  localparam int         TAG_W    = ADDR_W - OFF_W;
  localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_valid;
  logic                r_dirty;
  logic [TAG_W-1:0]    r_tag;
  logic [LINE_W-1:0]   r_line;
  logic [1:0]          r_gap_cnt;

  logic [TAG_W-1:0]    w_req_tag;
  logic                w_hit;
  logic [WORD_W-1:0]   w_word;
  logic [LINE_W-1:0]   w_merged;

  assign w_req_tag = cpu_addr[ADDR_W-1:OFF_W];
  assign w_hit     = r_valid && (r_tag == w_req_tag);
  assign cpu_rdata = w_word;

  ddr_line_merge u_merge (
    .i_line  (r_line),
    .i_off   (cpu_addr[OFF_W-1:0]),
    .i_be    (cpu_we),
    .i_wdata (cpu_wdata),
    .o_word  (w_word),
    .o_line  (w_merged)
  );

  // Next-state and DDR/CPU handshake outputs; DDR outputs are idle (zero) outside WB/RF
  always_comb begin
    w_next_state = r_state;
    cpu_stall    = 1'b0;
    ddr_en       = 1'b0;
    ddr_write    = 1'b0;
    ddr_addr     = '0;
    ddr_wdata    = '0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_en && !w_hit) begin
          cpu_stall = 1'b1;
          if (ddr_calib) begin
            w_next_state = (r_valid && r_dirty) ? ST_WB : ST_RF;
          end
        end
      end
      ST_WB: begin
        cpu_stall = 1'b1;
        ddr_en    = 1'b1;
        ddr_write = 1'b1;
        ddr_addr  = {r_tag, {OFF_W{1'b0}}};
        ddr_wdata = r_line;
        if (ddr_rdy) w_next_state = ST_WB_GAP;
      end
      ST_WB_GAP: begin
        cpu_stall = 1'b1;
        if (r_gap_cnt == 2'd0) w_next_state = ST_RF;
      end
      ST_RF: begin
        cpu_stall = 1'b1;
        ddr_en    = 1'b1;
        ddr_addr  = {w_req_tag, {OFF_W{1'b0}}};
        if (ddr_rdy) w_next_state = ST_RF_GAP;
      end
      ST_RF_GAP: begin
        cpu_stall = 1'b1;
        if (r_gap_cnt == 2'd0) w_next_state = ST_IDLE;
      end
      default: begin
        cpu_stall    = 1'b1;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus line/tag/flag updates; reset abandons any DDR transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_dirty   <= 1'b0;
      r_tag     <= '0;
      r_line    <= '0;
      r_gap_cnt <= 2'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (cpu_en && w_hit && (cpu_we != 4'b0000)) begin
            r_line  <= w_merged;
            r_dirty <= 1'b1;
          end
        end
        ST_WB: begin
          if (ddr_rdy) begin
            r_dirty   <= 1'b0;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        ST_RF: begin
          if (ddr_rdy) begin
            r_line    <= ddr_rdata;
            r_tag     <= w_req_tag;
            r_valid   <= 1'b1;
            r_dirty   <= 1'b0;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        ST_WB_GAP, ST_RF_GAP: begin
          if (r_gap_cnt != 2'd0) r_gap_cnt <= r_gap_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef DDR_LINE_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;
  logic [31:0] r_stat_wbs;

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_wbs    = r_stat_wbs;

  // Event counters: hit cycles, miss departures from IDLE, completed write-backs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_wbs    <= '0;
    end else begin
      if (r_state == ST_IDLE && cpu_en && w_hit) r_stat_hits <= r_stat_hits + 32'd1;
      if (r_state == ST_IDLE && (w_next_state == ST_WB || w_next_state == ST_RF))
        r_stat_misses <= r_stat_misses + 32'd1;
      if (r_state == ST_WB && ddr_rdy) r_stat_wbs <= r_stat_wbs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_line_buffer.sv
// tb/tb_ddr_line_buffer.sv - directed self-checking bench for ddr_line_buffer
module tb_ddr_line_buffer;

  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_en;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              ddr_calib;
  logic              ddr_en;
  logic              ddr_write;
  logic [ADDR_W-1:0] ddr_addr;
  logic [255:0]      ddr_wdata;
  logic [255:0]      ddr_rdata;
  logic              ddr_rdy;
`ifdef DDR_LINE_STATS_EN
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;
  logic [31:0]       stat_wbs;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr_line_buffer #(.ADDR_W(ADDR_W), .GAP_CYCLES(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_en    (cpu_en),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ddr_calib (ddr_calib),
    .ddr_en    (ddr_en),
    .ddr_write (ddr_write),
    .ddr_addr  (ddr_addr),
    .ddr_wdata (ddr_wdata),
    .ddr_rdata (ddr_rdata),
    .ddr_rdy   (ddr_rdy)
`ifdef DDR_LINE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_wbs    (stat_wbs)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = base | 32'(i);
    return r;
  endfunction

  logic [255:0] l1, l2, l3, exp_wb;

  initial begin
    l1 = mk(32'hAAAA0000);
    l2 = mk(32'hBBBB0000);
    l3 = mk(32'hCCCC0000);
    exp_wb = l1;
    exp_wb[63:32] = 32'hAAAA5678;

    reset = 1'b1; cpu_en = 1'b0; cpu_we = 4'b0; cpu_addr = '0; cpu_wdata = '0;
    ddr_calib = 1'b1; ddr_rdata = '0; ddr_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ddr_en", 256'(ddr_en), 256'(0));
    chk("rst_ddr_write", 256'(ddr_write), 256'(0));
    chk("rst_ddr_addr", 256'(ddr_addr), 256'(0));
    chk("rst_ddr_wdata", ddr_wdata, 256'(0));
    chk("rst_stall", 256'(cpu_stall), 256'(0));

    // 1: read miss at 0x40 on an empty buffer -> refill only
    cpu_en = 1'b1; cpu_addr = 30'h40;
    #1;
    chk("t1_miss_stall", 256'(cpu_stall), 256'(1));
    chk("t1_idle_ddr_en", 256'(ddr_en), 256'(0));
    tick();
    chk("t1_rf_en", 256'(ddr_en), 256'(1));
    chk("t1_rf_write", 256'(ddr_write), 256'(0));
    chk("t1_rf_addr", 256'(ddr_addr), 256'(30'h40));
    chk("t1_rf_stall", 256'(cpu_stall), 256'(1));
    tick();
    chk("t1_rf_hold", 256'(ddr_en), 256'(1));
    tick();
    chk("t1_rf_hold2", 256'(ddr_en), 256'(1));
    ddr_rdy = 1'b1; ddr_rdata = l1;
    tick();
    ddr_rdy = 1'b0;
    #1;
    chk("t1_gap_en", 256'(ddr_en), 256'(0));
    chk("t1_gap_stall", 256'(cpu_stall), 256'(1));
    tick();
    chk("t1_hit_stall", 256'(cpu_stall), 256'(0));
    chk("t1_hit_rdata", 256'(cpu_rdata), 256'(32'hAAAA0000));

    // 2: partial write hit at 0x41, then read it back
    cpu_addr = 30'h41; cpu_we = 4'b0011; cpu_wdata = 32'h12345678;
    #1;
    chk("t2_wr_stall", 256'(cpu_stall), 256'(0));
    chk("t2_wr_prewrite", 256'(cpu_rdata), 256'(32'hAAAA0001));
    tick();
    cpu_we = 4'b0;
    #1;
    chk("t2_rd_merged", 256'(cpu_rdata), 256'(32'hAAAA5678));
    chk("t2_rd_stall", 256'(cpu_stall), 256'(0));

    // 3: dirty miss at 0x80 -> write-back of merged line, gap, refill
    cpu_addr = 30'h80;
    #1;
    chk("t3_miss_stall", 256'(cpu_stall), 256'(1));
    tick();
    chk("t3_wb_en", 256'(ddr_en), 256'(1));
    chk("t3_wb_write", 256'(ddr_write), 256'(1));
    chk("t3_wb_addr", 256'(ddr_addr), 256'(30'h40));
    chk("t3_wb_data", ddr_wdata, exp_wb);
    ddr_rdy = 1'b1;
    tick();
    ddr_rdy = 1'b0;
    #1;
    chk("t3_wbgap_en", 256'(ddr_en), 256'(0));
    chk("t3_wbgap_stall", 256'(cpu_stall), 256'(1));
    tick();
    chk("t3_rf_en", 256'(ddr_en), 256'(1));
    chk("t3_rf_write", 256'(ddr_write), 256'(0));
    chk("t3_rf_addr", 256'(ddr_addr), 256'(30'h80));
    ddr_rdy = 1'b1; ddr_rdata = l2;
    tick();
    ddr_rdy = 1'b0;
    #1;
    chk("t3_rfgap_en", 256'(ddr_en), 256'(0));
    tick();
    chk("t3_hit_stall", 256'(cpu_stall), 256'(0));
    chk("t3_hit_rdata", 256'(cpu_rdata), 256'(32'hBBBB0000));

    // 4: clean miss at 0xC5 -> straight to refill, no write phase
    cpu_addr = 30'hC5;
    #1;
    chk("t4_miss_stall", 256'(cpu_stall), 256'(1));
    chk("t4_idle_write", 256'(ddr_write), 256'(0));
    tick();
    chk("t4_rf_en", 256'(ddr_en), 256'(1));
    chk("t4_rf_write", 256'(ddr_write), 256'(0));
    chk("t4_rf_addr", 256'(ddr_addr), 256'(30'hC0));
    ddr_rdy = 1'b1; ddr_rdata = l3;
    tick();
    ddr_rdy = 1'b0;
    #1;
    chk("t4_gap_write", 256'(ddr_write), 256'(0));
    tick();
    chk("t4_hit_stall", 256'(cpu_stall), 256'(0));
    chk("t4_hit_rdata", 256'(cpu_rdata), 256'(32'hCCCC0005));

    // 5: miss with calibration low waits in IDLE, then refill starts
    ddr_calib = 1'b0; cpu_addr = 30'h100;
    #1;
    chk("t5_nocal_stall", 256'(cpu_stall), 256'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_nocal_en", 256'(ddr_en), 256'(0));
      chk("t5_nocal_stall_hold", 256'(cpu_stall), 256'(1));
    end
    ddr_calib = 1'b1;
    #1;
    chk("t5_cal_same_cycle_en", 256'(ddr_en), 256'(0));
    tick();
    chk("t5_rf_en", 256'(ddr_en), 256'(1));
    chk("t5_rf_addr", 256'(ddr_addr), 256'(30'h100));

    // 6: reset during refill wait abandons it and invalidates the line
    tick();
    cpu_en = 1'b0; reset = 1'b1;
    tick();
    chk("t6_rst_en", 256'(ddr_en), 256'(0));
    chk("t6_rst_stall", 256'(cpu_stall), 256'(0));
`ifdef DDR_LINE_STATS_EN
    chk("t6_stat_hits", 256'(stat_hits), 256'(0));
    chk("t6_stat_misses", 256'(stat_misses), 256'(0));
    chk("t6_stat_wbs", 256'(stat_wbs), 256'(0));
`endif
    reset = 1'b0; ddr_calib = 1'b0; cpu_en = 1'b1; cpu_addr = 30'hC0;
    tick();
    chk("t6_invalid_stall", 256'(cpu_stall), 256'(1));
    chk("t6_invalid_en", 256'(ddr_en), 256'(0));
    cpu_addr = 30'h0;
    #1;
    chk("t6_tag0_invalid_stall", 256'(cpu_stall), 256'(1));

    cpu_en = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
